// File: rtl/axis_slave_if.sv
// AXI-Stream slave ingress: assembles {re, im} beat pairs into complex samples,
// buffers them in a small pair-FIFO and writes them to the FFT input memory.
module axis_slave_if #(
  parameter int S_TDATA_WDT      = 32,
  parameter int C_SAMPLE_WDT     = 16,
  parameter int C_FFT_SIZE_LOG2  = 10,
  parameter int INPUT_MEM_OFFSET = 0,
  parameter int S_FIFO_SIZE      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [S_TDATA_WDT-1:0]     S_AXIS_TDATA,
  input  logic                       S_AXIS_TVALID,
  input  logic                       S_AXIS_TLAST,
  output logic                       S_AXIS_TREADY,
  output logic [C_FFT_SIZE_LOG2-1:0] s_axis_if_addr,
  output logic [C_SAMPLE_WDT-1:0]    data_re_0_in,
  output logic [C_SAMPLE_WDT-1:0]    data_im_0_in,
  output logic                       push,
  input  logic                       mem_wr_ready,
  input  logic                       rx_start,
  output logic                       rx_done,
  output logic                       tlast_err,
  output logic                       sample_ovf,
  output logic                       s_axis_if_busy
);

  localparam int PW = $clog2(S_FIFO_SIZE);
  localparam int CW = PW + 1;
  localparam int BW = C_FFT_SIZE_LOG2 + 1;
  localparam int AW = C_FFT_SIZE_LOG2;
  localparam logic [AW-1:0] ADDR_INIT = AW'(INPUT_MEM_OFFSET);
  localparam logic [CW-1:0] FIFO_FULL = CW'(S_FIFO_SIZE);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic signed [C_SAMPLE_WDT-1:0] trunc_sample(
    input logic [S_TDATA_WDT-1:0] d);
    return $signed(d[C_SAMPLE_WDT-1:0]);
  endfunction

  // Bits from the sample sign bit upward must all agree for a lossless truncation.
  function automatic logic ext_ovf(input logic [S_TDATA_WDT-1:0] d);
    logic [S_TDATA_WDT-C_SAMPLE_WDT:0] top;
    top = d[S_TDATA_WDT-1:C_SAMPLE_WDT-1];
    return !((&top) || !(|top));
  endfunction

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          phase_q, phase_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          tlast_err_q, tlast_err_d;
  logic          sample_ovf_q, sample_ovf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic signed [C_SAMPLE_WDT-1:0] re_hold_q;
  logic signed [C_SAMPLE_WDT-1:0] fifo_re_q [S_FIFO_SIZE];
  logic signed [C_SAMPLE_WDT-1:0] fifo_im_q [S_FIFO_SIZE];

  logic tready, beat_acc, fifo_wr, fifo_ne, push_w, last_beat;

  assign tready    = (state_q == ST_RECV) && (cnt_q < FIFO_FULL);
  assign beat_acc  = S_AXIS_TVALID && tready;
  assign fifo_wr   = beat_acc && phase_q;
  assign fifo_ne   = (cnt_q != '0);
  assign push_w    = fifo_ne && mem_wr_ready &&
                     ((state_q == ST_RECV) || (state_q == ST_DRAIN));
  assign last_beat = (beat_q == '1);

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    phase_d      = phase_q;
    addr_d       = addr_q;
    tlast_err_d  = tlast_err_q;
    sample_ovf_d = sample_ovf_q;
    wr_ptr_d     = wr_ptr_q + PW'(fifo_wr);
    rd_ptr_d     = rd_ptr_q + PW'(push_w);
    cnt_d        = cnt_q + CW'(fifo_wr) - CW'(push_w);
    if (push_w) addr_d = addr_q + AW'(1);
    case (state_q)
      ST_IDLE: begin
        addr_d = ADDR_INIT;
        if (rx_start) begin
          state_d      = ST_RECV;
          beat_d       = '0;
          phase_d      = 1'b0;
          tlast_err_d  = 1'b0;
          sample_ovf_d = 1'b0;
        end
      end
      ST_RECV: begin
        if (beat_acc) begin
          beat_d  = beat_q + BW'(1);
          phase_d = ~phase_q;
          if (ext_ovf(S_AXIS_TDATA)) sample_ovf_d = 1'b1;
          // An early TLAST on an RE beat simply abandons the held half pair.
          if (last_beat) begin
            state_d = ST_DRAIN;
            if (!S_AXIS_TLAST) tlast_err_d = 1'b1;
          end else if (S_AXIS_TLAST) begin
            state_d     = ST_DRAIN;
            tlast_err_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if ((cnt_q == '0) || ((cnt_q == CW'(1)) && push_w)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      beat_q       <= '0;
      phase_q      <= 1'b0;
      addr_q       <= ADDR_INIT;
      tlast_err_q  <= 1'b0;
      sample_ovf_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      phase_q      <= phase_d;
      addr_q       <= addr_d;
      tlast_err_q  <= tlast_err_d;
      sample_ovf_q <= sample_ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (beat_acc && !phase_q) re_hold_q <= trunc_sample(S_AXIS_TDATA);
    if (fifo_wr) begin
      fifo_re_q[wr_ptr_q] <= re_hold_q;
      fifo_im_q[wr_ptr_q] <= trunc_sample(S_AXIS_TDATA);
    end
  end

  assign S_AXIS_TREADY  = tready;
  assign push           = push_w;
  assign s_axis_if_addr = addr_q;
  assign data_re_0_in   = fifo_ne ? fifo_re_q[rd_ptr_q] : '0;
  assign data_im_0_in   = fifo_ne ? fifo_im_q[rd_ptr_q] : '0;
  assign rx_done        = (state_q == ST_DONE);
  assign tlast_err      = tlast_err_q;
  assign sample_ovf     = sample_ovf_q;
  assign s_axis_if_busy = (state_q != ST_IDLE);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_wr && !push_w && (cnt_q == FIFO_FULL)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    push_w |-> fifo_ne);
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    cnt_q <= FIFO_FULL);
  a_addr_range: assert property (@(posedge clk) disable iff (rst)
    push_w |-> (int'(addr_q) < (1 << C_FFT_SIZE_LOG2)));
  a_tready_recv: assert property (@(posedge clk) disable iff (rst)
    S_AXIS_TREADY |-> (state_q == ST_RECV));
  a_done_pulse: assert property (@(posedge clk) disable iff (rst)
    rx_done |=> !rx_done);

endmodule

// File: tb/tb_axis_slave_if.sv
// Bench for axis_slave_if: table of sample vectors, scoreboard of expected
// memory writes, and directed sequences for backpressure, TLAST and reset cases.
module tb_axis_slave_if;
  localparam int L  = 3;
  localparam int NS = 1 << L;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0, tlast = 1'b0, mem_rdy = 1'b1, rx_start = 1'b0;
  logic        tready, push, rx_done, tlast_err, sample_ovf, busy;
  logic [L-1:0] addr;
  logic [15:0] dre, dim;

  axis_slave_if #(.S_TDATA_WDT(32), .C_SAMPLE_WDT(16), .C_FFT_SIZE_LOG2(L),
                  .INPUT_MEM_OFFSET(0), .S_FIFO_SIZE(4)) dut (
    .clk(clk), .rst(rst), .S_AXIS_TDATA(tdata), .S_AXIS_TVALID(tvalid),
    .S_AXIS_TLAST(tlast), .S_AXIS_TREADY(tready), .s_axis_if_addr(addr),
    .data_re_0_in(dre), .data_im_0_in(dim), .push(push), .mem_wr_ready(mem_rdy),
    .rx_start(rx_start), .rx_done(rx_done), .tlast_err(tlast_err),
    .sample_ovf(sample_ovf), .s_axis_if_busy(busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] re_beat;
    logic [31:0] im_beat;
    logic [15:0] exp_re;
    logic [15:0] exp_im;
  } vec_t;
  typedef struct {
    logic [L-1:0] addr;
    logic [15:0]  re;
    logic [15:0]  im;
  } exp_t;

  vec_t vt [NS];
  exp_t exp_q [$];
  int n_cmp = 0, n_fail = 0;
  int cyc = 0, acc_cnt = 0, push_cnt = 0, done_cnt = 0;
  int last_push_cyc = 0, done_cyc = 0;
  logic prev_done = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every memory write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (tvalid && tready) acc_cnt++;
      if (push) begin
        push_cnt++;
        last_push_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL push_unexpected: got addr 0x%0h data 0x%0h, want no write", addr, {dre, dim});
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("push_addr", 64'(addr), 64'(e.addr));
          check("push_data", 64'({dre, dim}), 64'({e.re, e.im}));
        end
      end
      if (rx_done) begin
        check("rx_done_single", 64'(prev_done), 64'(0));
        done_cnt++;
        done_cyc = cyc;
      end
      prev_done = rx_done;
    end else prev_done = 1'b0;
  end

  task automatic send_beat(input logic [31:0] d, input logic last);
    bit acc = 1'b0;
    int n = 0;
    tdata = d; tvalid = 1'b1; tlast = last;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("beat_accept_timeout", 64'(acc), 64'(1));
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  // Send pairs first..last; tlast_beat is the beat index carrying TLAST (-1: none).
  task automatic send_pairs(input int first, input int last, input int tlast_beat);
    for (int k = first; k <= last; k++) begin
      send_beat(vt[k].re_beat, (2 * k) == tlast_beat);
      if ((2 * k) == tlast_beat) return;
      exp_q.push_back('{addr: L'(k), re: vt[k].exp_re, im: vt[k].exp_im});
      send_beat(vt[k].im_beat, (2 * k + 1) == tlast_beat);
    end
  endtask

  task automatic start_frame();
    rx_start = 1'b1;
    @(posedge clk); #1;
    rx_start = 1'b0;
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == d0) check("rx_done_timeout", 64'(done_cnt - d0), 64'(1));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, a0, ps, d0;
    for (int k = 0; k < NS; k++) begin
      vt[k].re_beat = 32'(k);
      vt[k].im_beat = -32'(k);
      vt[k].exp_re  = 16'(k);
      vt[k].exp_im  = -16'(k);
    end

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_tready", 64'(tready), 64'(0));
    check("rst_push", 64'(push), 64'(0));
    check("rst_rx_done", 64'(rx_done), 64'(0));
    check("rst_tlast_err", 64'(tlast_err), 64'(0));
    check("rst_sample_ovf", 64'(sample_ovf), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_addr", 64'(addr), 64'(0));
    check("rst_data", 64'({dre, dim}), 64'(0));

    // Nominal frame
    p0 = push_cnt; d0 = done_cnt;
    start_frame();
    check("t1_busy", 64'(busy), 64'(1));
    check("t1_tready", 64'(tready), 64'(1));
    send_pairs(0, NS - 1, 2 * NS - 1);
    wait_done();
    check("t1_pushes", 64'(push_cnt - p0), 64'(NS));
    check("t1_done_cnt", 64'(done_cnt - d0), 64'(1));
    check("t1_done_latency", 64'(done_cyc - last_push_cyc), 64'(1));
    check("t1_tlast_err", 64'(tlast_err), 64'(0));
    check("t1_sample_ovf", 64'(sample_ovf), 64'(0));
    check("t1_idle", 64'(busy), 64'(0));
    check("t1_queue_empty", 64'(exp_q.size()), 64'(0));

    // Memory backpressure mid-frame
    p0 = push_cnt; a0 = acc_cnt;
    start_frame();
    fork
      send_pairs(0, NS - 1, 2 * NS - 1);
      begin
        repeat (4) @(posedge clk);
        #1 mem_rdy = 1'b0;
        ps = push_cnt;
        repeat (20) @(posedge clk);
        #2;
        check("t2_tready_low", 64'(tready), 64'(0));
        check("t2_no_push_stalled", 64'(push_cnt - ps), 64'(0));
        check("t2_buffered_beats", 64'((acc_cnt - a0) - 2 * (push_cnt - p0)), 64'(8));
        mem_rdy = 1'b1;
      end
    join
    wait_done();
    check("t2_pushes", 64'(push_cnt - p0), 64'(NS));
    check("t2_tlast_err", 64'(tlast_err), 64'(0));
    check("t2_queue_empty", 64'(exp_q.size()), 64'(0));

    // Early TLAST on beat 6 (an RE beat)
    p0 = push_cnt; d0 = done_cnt;
    start_frame();
    send_pairs(0, 3, 6);
    wait_done();
    check("t3_pushes", 64'(push_cnt - p0), 64'(3));
    check("t3_tlast_err", 64'(tlast_err), 64'(1));
    check("t3_done_cnt", 64'(done_cnt - d0), 64'(1));
    check("t3_idle", 64'(busy), 64'(0));
    check("t3_tready_idle", 64'(tready), 64'(0));
    check("t3_queue_empty", 64'(exp_q.size()), 64'(0));

    // Missing TLAST plus one out-of-range beat
    vt[2].re_beat = 32'h0001_2345;
    vt[2].exp_re  = 16'h2345;
    p0 = push_cnt;
    start_frame();
    check("t4_flags_cleared", 64'({tlast_err, sample_ovf}), 64'(0));
    send_pairs(0, NS - 1, -1);
    wait_done();
    check("t4_pushes", 64'(push_cnt - p0), 64'(NS));
    check("t4_tlast_err", 64'(tlast_err), 64'(1));
    check("t4_sample_ovf", 64'(sample_ovf), 64'(1));
    check("t4_queue_empty", 64'(exp_q.size()), 64'(0));
    vt[2].re_beat = 32'(2);
    vt[2].exp_re  = 16'(2);

    // Reset mid-frame after 5 beats, then a clean frame with a stray rx_start
    start_frame();
    send_pairs(0, 1, -1);
    send_beat(vt[2].re_beat, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("t5_rst_busy", 64'(busy), 64'(0));
    check("t5_rst_tready", 64'(tready), 64'(0));
    check("t5_rst_addr", 64'(addr), 64'(0));
    check("t5_rst_push", 64'(push), 64'(0));
    p0 = push_cnt; d0 = done_cnt;
    start_frame();
    send_pairs(0, 2, -1);
    start_frame();
    check("t5_still_recv", 64'(busy), 64'(1));
    send_pairs(3, NS - 1, 2 * NS - 1);
    wait_done();
    check("t5_pushes", 64'(push_cnt - p0), 64'(NS));
    check("t5_done_cnt", 64'(done_cnt - d0), 64'(1));
    check("t5_tlast_err", 64'(tlast_err), 64'(0));
    check("t5_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/axis_slave_if.md
Name: axis_slave_if

Overview:
- AXI-Stream slave ingress stage. It accepts time-domain samples from the DMA and writes them into the FFT input memory. It is the mirror of the egress path, which streams results out.
- Each complex sample arrives as two beats: real part first, imaginary part second. Each beat is sign-extended to S_TDATA_WDT.
- A small pair-FIFO decouples stream backpressure from memory write stalls.
- One frame is 2^C_FFT_SIZE_LOG2 samples, which is 2*N beats.

Parameters:
- S_TDATA_WDT, 32, stream data width; must be >= C_SAMPLE_WDT.
- C_SAMPLE_WDT, 16, width of the real and imaginary sample parts.
- C_FFT_SIZE_LOG2, 10, log2 of the frame length N.
- INPUT_MEM_OFFSET, 0, first memory address written.
- S_FIFO_SIZE, 4, pair-FIFO depth in complex samples; must be a power of 2 and >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- S_AXIS_TDATA  in  S_TDATA_WDT  stream data.
- S_AXIS_TVALID  in  1  stream valid.
- S_AXIS_TLAST  in  1  end of frame.
- S_AXIS_TREADY  out  1  stream ready.
- s_axis_if_addr  out  C_FFT_SIZE_LOG2  input memory write address.
- data_re_0_in  out  C_SAMPLE_WDT  real part to memory.
- data_im_0_in  out  C_SAMPLE_WDT  imaginary part to memory.
- push  out  1  memory write strobe; addr and data are valid in the same cycle.
- mem_wr_ready  in  1  memory accepts a write this cycle.
- rx_start  in  1  single-cycle pulse that arms reception of one frame.
- rx_done  out  1  single-cycle pulse when the frame is fully in memory.
- tlast_err  out  1  sticky: TLAST early or missing.
- sample_ovf  out  1  sticky: a beat's discarded upper bits were not a sign extension.
- s_axis_if_busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset values:
  - FSM goes to IDLE.
  - S_AXIS_TREADY=0, push=0, rx_done=0, tlast_err=0, sample_ovf=0, busy=0.
  - s_axis_if_addr=INPUT_MEM_OFFSET.
  - data outputs=0.
  - FIFO pointers and count=0; beat counter=0; phase=RE.
- Reset asserted mid-frame aborts everything the same cycle; FIFO contents are discarded.
- Beat acceptance: a beat is accepted when TVALID & TREADY.
- TREADY = (state==RECV) & (fifo_count < S_FIFO_SIZE). It may depend combinationally only on registered state.
- Beat decode:
  - RE-phase beat: low C_SAMPLE_WDT bits are latched into re_hold; phase flips to IM.
  - IM-phase beat: {re_hold, low bits} is written to the FIFO tail; phase flips to RE.
  - Truncation keeps the low C_SAMPLE_WDT bits. If bits [S_TDATA_WDT-1:C_SAMPLE_WDT-1] are not all equal, sample_ovf is set (sticky).
- FSM states:
  - IDLE: rx_start -> RECV. On entry, clear the counters, addr, tlast_err, sample_ovf and phase. rx_start in any other state is ignored.
  - RECV, normal end: accepting beat index 2N-1 -> DRAIN. If TLAST=0 on that beat, set tlast_err.
  - RECV, early TLAST: TLAST=1 on any beat index < 2N-1 sets tlast_err and goes to DRAIN.
    - If the early beat is an RE beat, the half pair is discarded.
    - The remaining memory locations are not written.
  - DRAIN: TREADY=0; stay until the FIFO is empty -> DONE.
  - DONE: rx_done=1 for exactly one cycle -> IDLE.
- Memory write side:
  - push = fifo_not_empty & mem_wr_ready & (state in RECV, DRAIN).
  - data_re_0_in/data_im_0_in are driven from the FIFO head (fall-through) whenever the FIFO is non-empty.
  - On push, pop the head and increment s_axis_if_addr modulo 2^C_FFT_SIZE_LOG2.
  - In IDLE, addr returns to INPUT_MEM_OFFSET.
- Simultaneous FIFO write and pop in one cycle: count is unchanged. This is legal when full, because TREADY is already low at full.
- Throughput: with TVALID=1 and mem_wr_ready=1 continuously, there are no bubbles. That is 1 push per 2 beats, and the FIFO never fills.
- Latency: the IM beat is accepted at cycle t; push for that pair occurs at cycle t+1 at the earliest.
- rx_done is asserted only after the last push.
- Beats arriving while not in RECV are not accepted, because TREADY=0.
- Assertions:
  - no FIFO overflow or underflow;
  - push implies addr < 2^C_FFT_SIZE_LOG2;
  - TREADY=0 outside RECV;
  - rx_done is never high on two consecutive cycles.

Test Plan:
1. Nominal frame:
   - Stimulus: C_FFT_SIZE_LOG2=3; rx_start; 16 beats with re=k and im=-k for k=0..7; TLAST on beat 15; mem_wr_ready=1.
   - Response: 8 pushes at addr 0..7 with matching data; rx_done 1 cycle after the last push; tlast_err=0.
2. Memory backpressure:
   - Stimulus: mem_wr_ready=0 for 20 cycles mid-frame.
   - Response: TREADY drops after 4 pairs are buffered; no data lost or reordered; resumes when ready returns.
3. Early TLAST:
   - Stimulus: TLAST on beat 6, an RE beat.
   - Response: 3 pushes; tlast_err=1; the half pair is discarded; rx_done is pulsed; FSM returns to IDLE.
4. Missing TLAST and overflow:
   - Stimulus: beat 15 has TLAST=0; one beat has TDATA=0x00012345.
   - Response: tlast_err=1; sample_ovf=1; stored value is 0x2345; all 8 pushes occur.
5. Reset and start handling:
   - Stimulus: assert rst after 5 beats, then rx_start and a nominal frame. Separately, rx_start during RECV.
   - Response: the post-reset frame lands at addr 0..7 correctly; the second rx_start has no effect.
